// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin bus arbiter.
//   NUM_REQ : number of requesters sharing the bus
//   PTR_W   : width of a requester index
//   state_e : arbiter FSM states
package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int PTR_W   = $clog2(NUM_REQ);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational round-robin priority pick.
//   req         : request vector, bit i = requester i
//   ptr         : index of the last granted requester
//   any         : at least one request is pending
//   pick_idx    : first requester found scanning from ptr+1, wrapping
//   pick_onehot : pick_idx as one-hot, zero when nothing is pending
module rr_priority_pick
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               any,
    output logic [PTR_W-1:0]   pick_idx,
    output logic [NUM_REQ-1:0] pick_onehot
);

    // Scan offsets from farthest to nearest so the nearest hit is the
    // last assignment. Offset NUM_REQ wraps to ptr itself: the previous
    // owner is the lowest-priority candidate.
    always_comb begin
        logic [PTR_W-1:0] idx;
        any      = 1'b0;
        pick_idx = '0;
        idx      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ptr + PTR_W'(k);
            if (req[idx]) begin
                any      = 1'b1;
                pick_idx = idx;
            end
        end
    end

    always_comb begin
        pick_onehot = '0;
        if (any) pick_onehot[pick_idx] = 1'b1;
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 tri-state result bus.
//   clk, rst_n     : clock, asynchronous active-low reset
//   req            : level requests, bit i = requester i
//   data_0..data_3 : per-requester source data
//   grant          : registered one-hot owner, zero when idle
//   select         : registered owner index, held through idle
//   enable         : registered bus-drive enable (= |grant)
//   bus_out        : data of the selected source while enabled, else Z
// An owner keeps the bus for up to MAX_HOLD consecutive cycles while it
// keeps requesting; on release the next pick loads on the same edge.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   data_0,
    input  logic [WIDTH-1:0]   data_1,
    input  logic [WIDTH-1:0]   data_2,
    input  logic [WIDTH-1:0]   data_3,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   select,
    output logic               enable,
    output logic [WIDTH-1:0]   bus_out
);

    localparam int              HW         = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   MAX_HOLD_C = HW'(MAX_HOLD);

    state_e               state_q,  state_d;
    logic [HW-1:0]        hold_q,   hold_d;
    logic [PTR_W-1:0]     ptr_q,    ptr_d;
    logic [NUM_REQ-1:0]   grant_q,  grant_d;
    logic [PTR_W-1:0]     select_q, select_d;
    logic                 enable_q, enable_d;

    logic                 pk_any;
    logic [PTR_W-1:0]     pk_idx;
    logic [NUM_REQ-1:0]   pk_onehot;
    logic                 take;

    logic [NUM_REQ-1:0][WIDTH-1:0] data_arr;
    assign data_arr = {data_3, data_2, data_1, data_0};

    rr_priority_pick u_pick (
        .req         (req),
        .ptr         (ptr_q),
        .any         (pk_any),
        .pick_idx    (pk_idx),
        .pick_onehot (pk_onehot)
    );

    // State register. ptr resets to the last index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            ptr_q    <= PTR_W'(NUM_REQ - 1);
            grant_q  <= '0;
            select_q <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            enable_q <= enable_d;
        end
    end

    // Next state. 'take' marks an edge that loads a fresh pick, either
    // from idle or on release of the current owner (no idle gap).
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        select_d = select_q;
        enable_d = enable_q;
        take     = 1'b0;
        case (state_q)
            ST_IDLE: take = pk_any;
            ST_GRANT: begin
                if (req[select_q] && (hold_q < MAX_HOLD_C)) begin
                    hold_d = hold_q + HW'(1);
                end else if (pk_any) begin
                    take = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    enable_d = 1'b0;
                    hold_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (take) begin
            state_d  = ST_GRANT;
            grant_d  = pk_onehot;
            select_d = pk_idx;
            enable_d = 1'b1;
            hold_d   = HW'(1);
            ptr_d    = pk_idx;
        end
    end

    // Outputs: straight from flops; the bus is the only combinational path.
    always_comb begin
        grant  = grant_q;
        select = select_q;
        enable = enable_q;
    end

    assign bus_out = enable_q ? data_arr[select_q] : {WIDTH{1'bz}};

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    localparam int W  = 32;
    localparam int MH = 4;

    logic           clk;
    logic           rst_n;
    logic [3:0]     req;
    logic [3:0][W-1:0] dat;
    wire  [3:0]     grant;
    wire  [1:0]     select;
    wire            enable;
    wire  [W-1:0]   bus_out;

    int checks   = 0;
    int failures = 0;

    mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data_0  (dat[0]),
        .data_1  (dat[1]),
        .data_2  (dat[2]),
        .data_3  (dat[3]),
        .grant   (grant),
        .select  (select),
        .enable  (enable),
        .bus_out (bus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: owner (-1 idle), burst length, last-granted index.
    int m_owner, m_cnt, m_ptr, m_sel;

    function automatic int rr_pick(logic [3:0] r, int p);
        for (int k = 1; k <= 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic model_rst();
        m_owner = -1; m_cnt = 0; m_ptr = 3; m_sel = 0;
    endtask

    task automatic model_tick();
        int p;
        if (m_owner >= 0 && req[m_owner] && m_cnt < MH) begin
            m_cnt++;
        end else begin
            p = rr_pick(req, m_ptr);
            if (p >= 0) begin
                m_owner = p; m_cnt = 1; m_ptr = p; m_sel = p;
            end else begin
                m_owner = -1; m_cnt = 0;
            end
        end
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // An undriven bus reads as Z in four-state simulators and as 0 in
    // two-state ones; source data is kept nonzero so a driven bus is caught.
    task automatic chk_bus(string nm, logic en, int sel);
        if (en) begin
            chk(nm, 64'(bus_out), 64'(dat[sel]));
        end else begin
            checks++;
            if (!(bus_out === {W{1'bz}} || bus_out === '0)) begin
                failures++;
                $display("FAIL %s actual=%0h required=Z at %0t", nm, bus_out, $time);
            end
        end
    endtask

    task automatic chk_all(string nm, logic [3:0] g, logic [1:0] s, logic en);
        chk({nm, ".grant"},  64'(grant),  64'(g));
        chk({nm, ".select"}, 64'(select), 64'(s));
        chk({nm, ".enable"}, 64'(enable), 64'(en));
        chk_bus({nm, ".bus"}, en, int'(s));
    endtask

    task automatic new_data();
        for (int i = 0; i < 4; i++) dat[i] = $urandom() | 32'h1;
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       en;
    } vec_t;

    vec_t tbl[27];

    initial begin
        // req=1111: four bursts of four, then back to 0
        for (int i = 0; i < 16; i++) tbl[i] = '{4'b1111, 4'b0001 << (i / 4), 2'(i / 4), 1'b1};
        tbl[16] = '{4'b1111, 4'b0001, 2'd0, 1'b1};
        tbl[17] = '{4'b1001, 4'b0001, 2'd0, 1'b1};
        tbl[18] = '{4'b1000, 4'b1000, 2'd3, 1'b1};  // owner 0 drops, 3 takes over
        tbl[19] = '{4'b0000, 4'b0000, 2'd3, 1'b0};  // idle, select held
        tbl[20] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[21] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[22] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[23] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[24] = '{4'b0100, 4'b0100, 2'd2, 1'b1};  // sole requester re-granted
        tbl[25] = '{4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[26] = '{4'b0010, 4'b0010, 2'd1, 1'b1};

        rst_n = 1'b0;
        req   = 4'b1111;
        new_data();
        model_rst();
        #1;
        chk_all("rst0", 4'b0000, 2'd0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all("rst_clk", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        model_rst();

        for (int i = 0; i < 27; i++) begin
            req = tbl[i].req;
            step();
            chk_all($sformatf("tbl%0d", i), tbl[i].grant, tbl[i].sel, tbl[i].en);
            new_data();
            #1;
            chk_bus($sformatf("tbl%0d.newdata", i), tbl[i].en, int'(tbl[i].sel));
        end

        // asynchronous reset mid-burst with owner 1
        req = 4'b0010;
        step();
        chk_all("burst1", 4'b0010, 2'd1, 1'b1);
        #2;
        rst_n = 1'b0;
        model_rst();
        #1;
        chk_all("async_rst", 4'b0000, 2'd0, 1'b0);
        req = 4'b1010;
        @(posedge clk); #1;
        chk_all("async_rst_hold", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_all("post_rst", 4'b0010, 2'd1, 1'b1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       req = 4'b0000;
                1:       req = req;
                default: req = 4'($urandom_range(0, 15));
            endcase
            step();
            chk_all($sformatf("rnd%0d", n), (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000,
                    2'(m_sel), m_owner >= 0);
            new_data();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
